// File: rtl/cw_sequencer.sv
// -----------------------------------------------------------------------------
// cw_sequencer
//
// Replays a programmable table of {control word, constant K} entries into the
// LEGv8 Datapath cw/k inputs, one entry per clock. Supports run-once, loop and
// single-step modes, plus stall and halt. It lets the datapath run without the
// Control Unit.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-low reset
//   wr_en/wr_addr/wr_cw/wr_k   table write port (accepted only in IDLE)
//   start, mode, last_addr     sequence launch; mode and last_addr latched
//   step                  advance one entry in single-step mode
//   stall, halt           hold current entry / abort to IDLE
//   cw, k, valid, idx     registered entry presented to the Datapath
//   busy, done            state != IDLE / one-cycle completion pulse
//   loop_count            completed passes in loop mode (saturating)
//
// Optional feature macro: CW_SEQ_ZERO_SKIP_EN
//   Adds zero_in and wr_skip. An entry stored with skip=1 that is emitted
//   while zero_in=1 (and not stalled) skips the following entry.
// -----------------------------------------------------------------------------
module cw_sequencer #(
    parameter int                  CW_WIDTH   = 29,
    parameter int                  K_WIDTH    = 64,
    parameter int                  DEPTH      = 16,
    parameter int                  ADDR_WIDTH = 4,
    parameter logic [CW_WIDTH-1:0] NOP_CW     = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CW_WIDTH-1:0]   wr_cw,
    input  logic [K_WIDTH-1:0]    wr_k,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  stall,
    input  logic                  halt,
`ifdef CW_SEQ_ZERO_SKIP_EN
    input  logic                  zero_in,
    input  logic                  wr_skip,
`endif
    output logic [CW_WIDTH-1:0]   cw,
    output logic [K_WIDTH-1:0]    k,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic [15:0]           loop_count
);

    // state     | meaning
    // ----------+-------------------------------------------------------------
    // IDLE      | table writable, waiting for start
    // RUN       | one entry per cycle (run-once or loop)
    // STEP_WAIT | single-step: entry shown for one cycle per step, else NOP
    // DONE      | one-cycle done pulse, then back to IDLE
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_STEP_WAIT = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] LAST_MAX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_EXT   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   TWO_EXT   = (ADDR_WIDTH + 1)'(2);

    logic [CW_WIDTH-1:0] tbl_cw [DEPTH];
    logic [K_WIDTH-1:0]  tbl_k  [DEPTH];

    logic [1:0]            state_q, state_n;
    logic [CW_WIDTH-1:0]   cw_q, cw_n;
    logic [K_WIDTH-1:0]    k_q, k_n;
    logic                  valid_q, valid_n;
    logic                  done_q, done_n;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] idx_q, idx_n;
    logic [15:0]           lc_q, lc_n;
    logic [1:0]            mode_q, mode_n;
    logic [ADDR_WIDTH-1:0] last_q, last_n;

    logic                  load, nop;
    logic [ADDR_WIDTH-1:0] load_idx;
    logic [ADDR_WIDTH-1:0] start_last;
    logic [ADDR_WIDTH:0]   last_ext, adv, wrap;
    logic                  past_last;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic                  skip_take;

    // Table: not reset, writable only while idle and in range.
    always_ff @(posedge clock) begin
        if (wr_en && state_q == S_IDLE && ({1'b0, wr_addr} < DEPTH_EXT)) begin
            tbl_cw[wr_addr] <= wr_cw;
            tbl_k[wr_addr]  <= wr_k;
        end
    end

`ifdef CW_SEQ_ZERO_SKIP_EN
    logic tbl_skip [DEPTH];
    logic skip_q, skip_n;
    logic arm_q, arm_n;
    logic skip_now;

    always_ff @(posedge clock) begin
        if (wr_en && state_q == S_IDLE && ({1'b0, wr_addr} < DEPTH_EXT)) begin
            tbl_skip[wr_addr] <= wr_skip;
        end
    end

    // In single-step the skip decision is made in the entry's display cycle,
    // but the step that consumes it can arrive later, so it is remembered.
    assign skip_now  = valid_q && skip_q && zero_in && !stall;
    assign skip_take = skip_now || arm_q;

    always_comb begin
        skip_n = skip_q;
        arm_n  = arm_q;
        if (load) begin
            skip_n = tbl_skip[load_idx];
        end else if (nop) begin
            skip_n = 1'b0;
        end
        if (halt || state_q != S_STEP_WAIT) begin
            arm_n = 1'b0;
        end else if (!stall) begin
            arm_n = step ? 1'b0 : (arm_q || skip_now);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            skip_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            skip_q <= skip_n;
            arm_q  <= arm_n;
        end
    end
`else
    assign skip_take = 1'b0;
`endif

    assign start_last = ({1'b0, last_addr} >= DEPTH_EXT) ? LAST_MAX : last_addr;

    // Next index; a wrap past last_addr is taken modulo (last_addr + 1).
    always_comb begin
        last_ext  = {1'b0, last_q};
        adv       = {1'b0, idx_q} + (skip_take ? TWO_EXT : ONE_EXT);
        past_last = (adv > last_ext);
        wrap      = adv - (last_ext + ONE_EXT);
        if (wrap > last_ext) begin
            wrap = '0;
        end
        next_idx = past_last ? wrap[ADDR_WIDTH-1:0] : adv[ADDR_WIDTH-1:0];
    end

    always_comb begin
        state_n  = state_q;
        cw_n     = cw_q;
        k_n      = k_q;
        valid_n  = valid_q;
        done_n   = 1'b0;
        idx_n    = idx_q;
        lc_n     = lc_q;
        mode_n   = mode_q;
        last_n   = last_q;
        load     = 1'b0;
        nop      = 1'b0;
        load_idx = idx_q;

        if (halt) begin
            state_n = S_IDLE;
            nop     = 1'b1;
            idx_n   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !wr_en) begin
                        mode_n   = mode;
                        last_n   = start_last;
                        lc_n     = '0;
                        load     = 1'b1;
                        load_idx = '0;
                        state_n  = (mode == MODE_STEP) ? S_STEP_WAIT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (past_last && mode_q != MODE_LOOP) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                            nop     = 1'b1;
                        end else begin
                            load     = 1'b1;
                            load_idx = next_idx;
                            if (past_last && lc_q != 16'hFFFF) begin
                                lc_n = lc_q + 16'd1;
                            end
                        end
                    end
                end
                S_STEP_WAIT: begin
                    if (!stall) begin
                        if (step) begin
                            if (past_last) begin
                                state_n = S_DONE;
                                done_n  = 1'b1;
                                nop     = 1'b1;
                            end else begin
                                load     = 1'b1;
                                load_idx = next_idx;
                            end
                        end else begin
                            nop = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    nop     = 1'b1;
                end
                default: begin
                    state_n = S_IDLE;
                    nop     = 1'b1;
                end
            endcase
        end

        if (load) begin
            cw_n    = tbl_cw[load_idx];
            k_n     = tbl_k[load_idx];
            valid_n = 1'b1;
            idx_n   = load_idx;
        end else if (nop) begin
            cw_n    = NOP_CW;
            k_n     = '0;
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cw_q    <= NOP_CW;
            k_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            lc_q    <= '0;
            mode_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_n;
            cw_q    <= cw_n;
            k_q     <= k_n;
            valid_q <= valid_n;
            done_q  <= done_n;
            busy_q  <= (state_n != S_IDLE);
            idx_q   <= idx_n;
            lc_q    <= lc_n;
            mode_q  <= mode_n;
            last_q  <= last_n;
        end
    end

    assign cw         = cw_q;
    assign k          = k_q;
    assign valid      = valid_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign idx        = idx_q;
    assign loop_count = lc_q;

endmodule

// File: doc/cw_sequencer.md
# cw_sequencer

Parametrised control-word sequencer for the LEGv8 datapath. It holds a programmable table of {control word, constant K} entries and replays them into the Datapath's `cw`/`k` inputs one entry per clock. It supports run-once, loop and single-step modes, plus stall and halt. It replaces hand-timed control-word stimulus and lets the datapath be exercised without the Control Unit, both in simulation and on board.

## Interface
- `CW_WIDTH`, 29, control-word width (bit 24 regWrite, bit 25 memWrite as in Datapath)
- `K_WIDTH`, 64, constant width
- `DEPTH`, 16, table entries; must satisfy DEPTH ≤ 2^ADDR_WIDTH
- `ADDR_WIDTH`, 4, table index width
- `NOP_CW`, 0, control word driven when no entry is valid (regWrite=memWrite=0)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low
- `wr_en`, `wr_addr`, `wr_cw`, `wr_k`  in  1/ADDR_WIDTH/CW_WIDTH/K_WIDTH  table write port
- `start`  in  1  begin sequence at entry 0
- `mode`  in  2  00 run-once, 01 loop, 10 single-step, 11 reserved (treated as 00)
- `step`  in  1  advance one entry in single-step
- `last_addr`  in  ADDR_WIDTH  final entry index
- `stall`  in  1  hold current entry
- `halt`  in  1  abort to IDLE
- `cw`  out  CW_WIDTH  control word to Datapath
- `k`  out  K_WIDTH  constant to Datapath
- `valid`  out  1  `cw`/`k` hold a table entry this cycle
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `idx`  out  ADDR_WIDTH  index of the entry on `cw`
- `loop_count`  out  16  completed passes in loop mode

## Operation
- States: IDLE, RUN, STEP_WAIT, DONE.
- **IDLE**
  - Writes are accepted.
  - `start` with `wr_en` low → RUN (modes 00/01) or STEP_WAIT (mode 10).
  - `mode` and `last_addr` are latched at start. A `last_addr` ≥ DEPTH is clamped to DEPTH−1.
  - `start` with `wr_en` high is ignored.
- **RUN**
  - One entry is emitted per cycle with `valid`=1.
  - After emitting `last_addr`: mode 00 → DONE; mode 01 → wrap to entry 0 and increment `loop_count`, which saturates at 0xFFFF.
- **STEP_WAIT**
  - On entry, entry 0 is emitted for one cycle. Otherwise `cw`=NOP_CW and `valid`=0.
  - Each `step` pulse emits the next entry for exactly one cycle.
  - A `step` after `last_addr` has been emitted → DONE.
- **DONE**: `done`=1 for one cycle, `cw`=NOP_CW, then → IDLE.
- `stall`=1 (RUN/STEP_WAIT): the current `cw`, `k`, `idx` and `valid` are held, and the index does not advance. `step` is ignored while stalled.
- `halt`=1 in any state → IDLE next cycle, `cw`=NOP_CW, no `done` pulse. `halt` beats `stall` and `start`.
- Writes in a non-IDLE state, or with `wr_addr` ≥ DEPTH, are dropped.
- Table contents are not reset; only control state is.

## Timing
- Reset (`reset`=0 at a clock edge):
  - state=IDLE, `cw`=NOP_CW, `k`=0, `valid`=0, `busy`=0, `done`=0, `idx`=0, `loop_count`=0.
  - Reset mid-run aborts immediately and has the same effect as halt.
- All outputs are registered.
- `start` at edge N → entry 0 on `cw` from edge N+1 (one-cycle latency), entry i at edge N+1+i absent stalls.
- A table write at edge N is readable by a `start` at edge N+1.
- `step` at edge N → entry on `cw` at edge N+1 for one cycle.
- Run-once of L+1 entries: `done` is asserted at edge N+L+2 and `busy` falls at N+L+3.
- `loop_count` increments on the same edge that entry 0 re-appears.

## Configuration
- `CW_SEQ_ZERO_SKIP_EN` defined:
  - Adds input `zero_in` (1, Datapath Zero) and input `wr_skip` (1, a per-entry skip flag written with the entry).
  - If the emitted entry has skip=1 and `zero_in`=1 in its cycle with `stall`=0, the next entry is skipped (index +2).
  - If the skip passes `last_addr`: mode 00 → DONE; mode 01 → wrap per modulo (last_addr+1).
- Macro undefined: `zero_in` and `wr_skip` are absent, no flag storage exists, and the index always advances by 1.

## Test plan
- Load the 11 MOVZ/ADD/STUR/LDUR/B/CBZ/SUBS words at indices 0–10, `last_addr`=10, mode 00, start at edge N → entries on `cw` at edges N+1..N+11, `done` at N+12, X4=3, X5=3 in the Datapath.
- Mode 01, `last_addr`=2 → sequence 0,1,2,0,1,2. `loop_count` goes 1 then 2 when entry 0 reappears. `halt` → NOP_CW next cycle, `done`=0.
- `stall` held 3 cycles on entry 1 → entry 1 present for 4 cycles, then entry 2. A `halt`+`stall` cycle → IDLE.
- Mode 10 with 3 entries: entry 0 for one cycle, then NOP_CW. Three `step` pulses → entries 1, 2, then `done`. `step` during `stall` is ignored.
- `reset`=0 mid-RUN → all outputs at reset values next edge. A write while busy, or to `wr_addr`=DEPTH, leaves the table unchanged on readback.
- With `CW_SEQ_ZERO_SKIP_EN`: entry 1 skip=1, `zero_in`=1 → sequence 0,1,3. With `zero_in`=0 → sequence 0,1,2,3.
